// File: rtl/framer_pkg.sv
// Shared types, constants and size helpers for the sample framer.
// Imported by the framer top and its testbench.
package framer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SEQ,
        DATA,
        CSUM
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

    function automatic int frame_bytes(input int channels, input int width);
        return 3 + channels * bytes_per_word(width);
    endfunction

endpackage

// File: rtl/sample_framer_if.sv
// Byte stream valid/ready link from framer to UART transmitter.
// master: drives tx_data/tx_valid, samples tx_ready; slave: the reverse.
interface sample_framer_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector for a clk-synchronous word clock.
// Ports: clk, rst_n (async low), i_level in, o_rise = i_level & ~previous.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= 1'b0;
        else        r_q <= i_level;
    end

    assign o_rise = i_level & ~r_q;

endmodule

// File: rtl/sample_framer.sv
// Captures all channel words on a word-clock edge and streams one frame:
// sync, seq, data MSB-first, xor csum. Ports: clk, rst_n, sample_valid,
// sample_data, tx (byte link master), busy, overrun, drop_count.
module sample_framer
    import framer_pkg::*;
#(
    parameter int         CHANNELS  = 2,
    parameter int         WIDTH     = 16,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sample_valid,
    input  logic [CHANNELS*WIDTH-1:0] sample_data,
    sample_framer_if.master           tx,
    output logic                      busy,
    output logic                      overrun,
    output logic [7:0]                drop_count
);

    localparam int BPW   = bytes_per_word(WIDTH);
    localparam int NB    = CHANNELS * BPW;
    localparam int IW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int NSLOT = 1 << IW;

    state_t                    r_state;
    state_t                    w_next;
    logic [CHANNELS*WIDTH-1:0] r_shadow;
    logic [7:0]                r_seq;
    logic [7:0]                r_seq_sh;
    logic [7:0]                r_csum;
    logic [7:0]                r_drops;
    logic [IW-1:0]             r_idx;
    logic                      r_overrun;

    logic       w_rise;
    logic       w_valid;
    logic       w_xfer;
    logic       w_last;
    logic       w_accept;
    logic       w_drop;
    logic [7:0] w_tx_data;
    logic [7:0] w_bytes [NSLOT];

    rise_detect u_rise (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_level (sample_valid),
        .o_rise  (w_rise)
    );

    assign w_valid = (r_state != IDLE);
    assign w_xfer  = w_valid & tx.tx_ready;
    assign w_last  = (r_idx == IW'(NB - 1));

    // An edge landing on the CSUM transfer starts the next frame at once.
    assign w_accept = w_rise & ((r_state == IDLE) |
                                ((r_state == CSUM) & w_xfer));
    assign w_drop   = w_rise & ~w_accept;

    // Byte i of the payload: channel i/BPW, most significant byte first.
    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            w_bytes[i] = 8'h00;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            for (int b = 0; b < BPW; b++) begin
                w_bytes[c*BPW + b] = r_shadow[c*WIDTH + (BPW-1-b)*8 +: 8];
            end
        end
    end

    always_comb begin
        w_tx_data = 8'h00;
        unique case (r_state)
            IDLE:    w_tx_data = 8'h00;
            SYNC:    w_tx_data = SYNC_BYTE;
            SEQ:     w_tx_data = r_seq_sh;
            DATA:    w_tx_data = w_bytes[r_idx];
            CSUM:    w_tx_data = r_csum;
            default: w_tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_rise) w_next = SYNC;
            SYNC: if (w_xfer) w_next = SEQ;
            SEQ:  if (w_xfer) w_next = DATA;
            DATA: if (w_xfer && w_last) w_next = CSUM;
            CSUM: if (w_xfer) w_next = w_rise ? SYNC : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_seq     <= 8'h00;
            r_seq_sh  <= 8'h00;
            r_csum    <= 8'h00;
            r_drops   <= 8'h00;
            r_idx     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_drop;
            if (w_rise) r_seq <= r_seq + 8'd1;
            if (w_drop && (r_drops != 8'hFF)) r_drops <= r_drops + 8'd1;
            if (w_accept) begin
                r_shadow <= sample_data;
                r_seq_sh <= r_seq;
                r_csum   <= 8'h00;
                r_idx    <= '0;
            end else if (w_xfer) begin
                if ((r_state == SEQ) || (r_state == DATA)) begin
                    r_csum <= r_csum ^ w_tx_data;
                end
                if (r_state == DATA) r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign tx.tx_data  = w_tx_data;
    assign tx.tx_valid = w_valid;
    assign busy        = w_valid;
    assign overrun     = r_overrun;
    assign drop_count  = r_drops;

endmodule

// File: tb/tb_sample_framer.sv
// Directed bench for sample_framer: frames, stalls, overrun, wrap, reset.
// Two 16-bit channels, 7-byte frames.
module tb_sample_framer;

    logic        clk;
    logic        rst_n;
    logic        sample_valid;
    logic [31:0] sample_data;
    logic        tx_ready;
    logic        busy;
    logic        overrun;
    logic [7:0]  drop_count;

    sample_framer_if tx_if();

    wire [7:0] tx_data  = tx_if.tx_data;
    wire       tx_valid = tx_if.tx_valid;
    assign tx_if.tx_ready = tx_ready;

    sample_framer #(
        .CHANNELS  (2),
        .WIDTH     (16),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .tx           (tx_if),
        .busy         (busy),
        .overrun      (overrun),
        .drop_count   (drop_count)
    );

    localparam logic [31:0] BASE = {16'hABCD, 16'h1234};

    int         n_chk;
    int         n_err;
    logic [7:0] rx_q[$];
    int         first_wait;
    int         busy_cnt;
    int         ov_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        tx_ready     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Collect one 7-byte frame. Optionally raise the start edge first,
    // raise a further edge at iteration edge_at, swap data at that point.
    task automatic rx_frame(input bit start_edge, input bit rnd,
                            input int edge_at, input bit swap);
        logic       stall;
        logic [7:0] held;
        int         i;
        rx_q.delete();
        first_wait = -1;
        busy_cnt   = 0;
        ov_cnt     = 0;
        stall      = 1'b0;
        held       = 8'h00;
        if (start_edge) begin
            @(negedge clk);
            sample_valid = 1'b1;
        end
        i = 0;
        while (rx_q.size() < 7 && i < 400) begin
            @(negedge clk);
            sample_valid = (i == edge_at);
            if (swap && i == edge_at) sample_data = 32'hDEADBEEF;
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (busy) busy_cnt++;
            if (overrun) ov_cnt++;
            if (stall && tx_valid) chk("stall_stable", tx_data, held);
            if (tx_valid && tx_ready) begin
                if (first_wait < 0) first_wait = i;
                rx_q.push_back(tx_data);
            end
            stall = tx_valid && !tx_ready;
            held  = tx_data;
            i++;
        end
        chk("rx_len", rx_q.size(), 7);
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] seq);
        logic [7:0] e[7];
        e[0] = 8'hA5;
        e[1] = seq;
        e[2] = 8'h12;
        e[3] = 8'h34;
        e[4] = 8'hAB;
        e[5] = 8'hCD;
        e[6] = seq ^ e[2] ^ e[3] ^ e[4] ^ e[5];
        for (int i = 0; i < 7; i++) begin
            if (i < rx_q.size()) begin
                chk($sformatf("%s_b%0d", tag, i), rx_q[i], e[i]);
            end
        end
    endtask

    initial begin
        n_chk        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        tx_ready     = 1'b0;
        sample_data  = BASE;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_drops", drop_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_tx_valid", tx_valid, 0);

        // Basic frame
        rx_frame(1, 0, -1, 0);
        chk_frame("basic", 8'h00);
        chk("basic_busy_cycles", busy_cnt, 7);
        chk("basic_latency", first_wait, 0);
        @(negedge clk);
        #1;
        chk("basic_busy_after", busy, 0);
        chk("basic_valid_after", tx_valid, 0);

        // Backpressure
        rx_frame(1, 1, -1, 0);
        chk_frame("bp", 8'h01);
        chk("bp_overrun", ov_cnt, 0);

        // Overrun during byte 3
        do_reset();
        rx_frame(1, 0, 3, 1);
        chk_frame("ovr", 8'h00);
        chk("ovr_pulses", ov_cnt, 1);
        chk("ovr_drops", drop_count, 1);
        sample_data = BASE;
        rx_frame(1, 0, -1, 0);
        chk_frame("ovr_next", 8'h02);

        // Back-to-back: edge on the CSUM transfer
        rx_frame(1, 0, 6, 0);
        chk_frame("b2b_a", 8'h03);
        chk("b2b_a_overrun", ov_cnt, 0);
        rx_frame(0, 0, -1, 0);
        chk_frame("b2b_b", 8'h04);
        chk("b2b_gap", first_wait, 0);
        chk("b2b_b_overrun", ov_cnt, 0);
        chk("b2b_drops", drop_count, 1);

        // Sequence wrap
        do_reset();
        for (int k = 0; k < 257; k++) begin
            rx_frame(1, 0, -1, 0);
            chk_frame($sformatf("wrap%0d", k), 8'(k));
        end

        // drop_count saturation: stall a frame and hammer edges
        @(negedge clk);
        tx_ready     = 1'b0;
        sample_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            @(negedge clk);
            sample_valid = 1'b1;
        end
        @(negedge clk);
        sample_valid = 1'b0;
        #1;
        chk("sat_drops", drop_count, 255);
        chk("sat_valid_held", tx_valid, 1);
        rx_frame(0, 0, -1, 0);
        chk_frame("sat_frame", 8'h01);

        // Reset mid-frame
        @(negedge clk);
        tx_ready     = 1'b1;
        sample_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            sample_valid = 1'b0;
        end
        #1;
        chk("mid_in_data", tx_data, 8'h12);
        rst_n = 1'b0;
        #1;
        chk("mid_tx_valid", tx_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_drops", drop_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_no_resume", tx_valid, 0);
        rx_frame(1, 0, -1, 0);
        chk_frame("mid_next", 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sample_framer.md
# sample_framer

Multi-channel sample framer. It sits between the sinc3 decimation filters and the byte-wide UART transmitter. On each new-sample event it captures all channel words at once, then sends one framed byte stream over a valid/ready handshake: sync byte, sequence number, channel data MSB-first, XOR checksum. It replaces the single-channel direct filter-to-UART connection and adds channel count, backpressure and overrun accounting.

## Interface
- `CHANNELS`, 2 — number of filtered channels per frame, 1..8
- `WIDTH`, 16 — bits per channel word; must be a multiple of 8
- `SYNC_BYTE`, 8'hA5 — first byte of every frame
- `clk` in 1 — system clock, 75 MHz
- `rst_n` in 1 — reset; one clock, asynchronous, active-low
- `sample_valid` in 1 — word clock, synchronous to `clk`; a 0→1 transition marks a new sample set
- `sample_data` in CHANNELS*WIDTH — channel words; channel 0 in the LSBs
- `tx_data` out 8 — byte to the UART transmitter
- `tx_valid` out 1 — `tx_data` is valid
- `tx_ready` in 1 — the transmitter accepts a byte
- `busy` out 1 — a frame is in progress
- `overrun` out 1 — one-cycle pulse when a sample edge is dropped
- `drop_count` out 8 — number of dropped sample edges; saturates at 255

## Operation
- **Edge detect:** register `sample_valid` into `sv_q`. A rising edge is `sample_valid & ~sv_q`.
- **Sequence counter:** 8 bits. It increments on every rising edge, whether accepted or dropped, so the receiver can see gaps. It wraps from 255 to 0.
- **Frame length:** `3 + CHANNELS*WIDTH/8` bytes, in this order:
  - `SYNC_BYTE`
  - SEQ (the value of the counter before the increment for this edge)
  - channel 0 bytes MSB first, then channel 1, and so on
  - CSUM, the XOR of SEQ and all data bytes (the sync byte is excluded)
- **Capture:** on an accepted edge, latch all of `sample_data` and SEQ into shadow registers. Later changes on `sample_data` have no effect on the frame in progress.
- **FSM states:** IDLE, SYNC, SEQ, DATA, CSUM.
  - IDLE→SYNC on a rising edge.
  - SYNC→SEQ, SEQ→DATA and DATA→CSUM advance on a transfer (`tx_valid & tx_ready`).
  - DATA uses a byte index `0..CHANNELS*WIDTH/8-1` and leaves on the transfer of the last index.
  - CSUM→IDLE on transfer.
  - If a rising edge arrives in the same cycle as the CSUM transfer, go CSUM→SYNC and accept the edge (no overrun).
- **Handshake:**
  - A byte transfers when `tx_valid & tx_ready`.
  - While `tx_valid` is high and `tx_ready` is low, `tx_data` stays stable.
  - `tx_valid` never drops without a transfer, except on reset.
  - `tx_valid` does not depend combinationally on `tx_ready`.
- **Overrun:** a rising edge in any state other than IDLE (and other than the CSUM-transfer case above) is dropped:
  - shadow registers are unchanged
  - `overrun` pulses for one cycle
  - `drop_count` increments unless it is already 255
  - the sequence counter still increments
- **Checksum:** an 8-bit accumulator. Cleared on capture, updated with each SEQ and DATA byte on its transfer.
- **Reset values:** `tx_data`=0, `tx_valid`=0, `busy`=0, `overrun`=0, `drop_count`=0. Sequence counter=0, `sv_q`=0, state=IDLE.
- **Reset mid-frame:** the frame is abandoned immediately and no partial-frame completion follows.

## Timing
- **Capture latency:** rising edge seen at clock edge k → `tx_valid`=1 with `SYNC_BYTE` from edge k.
- **Byte throughput:** with `tx_ready` held high, one byte per cycle, so a frame takes `3+CHANNELS*WIDTH/8` cycles.
- **Back-to-back frames:** when the edge coincides with the CSUM transfer, the next SYNC follows in the very next cycle with no idle gap.
- **`busy`:** high from capture through the CSUM transfer cycle.
- **`overrun`:** registered; it pulses in the cycle after the dropped edge is sampled.
- **Rate constraint:** the frame must fit within one word-clock period, or frames will be dropped. At 115200 baud, 2×16-bit channels need 7 bytes (about 608 µs).

## Structure
- Package `framer_pkg` holds:
  - the state enum (IDLE, SYNC, SEQ, DATA, CSUM)
  - the default `SYNC_BYTE` constant
  - the function `frame_bytes(CHANNELS, WIDTH)`
  - the function `bytes_per_word(WIDTH)`
- Sub-module `rise_detect`: the `sv_q` register plus edge output, with async active-low reset. It is reused for other word-clock consumers.
- Byte selection from the shadow register is indexed muxing inside `sample_framer`. There is no separate module for it.

## Test plan
- **Basic frame:** CHANNELS=2, data ch0=16'h1234, ch1=16'hABCD, one edge with `tx_ready`=1 → bytes A5,00,12,34,AB,CD,40. `busy` is high for 7 cycles.
- **Backpressure:** same stimulus with `tx_ready` toggled pseudo-randomly → identical byte sequence, and `tx_data` is stable throughout every stall.
- **Overrun:** a second edge at byte 3 of a frame → `overrun` pulses once, `drop_count`=1, and the current frame completes unchanged. The next accepted frame carries SEQ=02.
- **Back-to-back:** an edge coincident with the CSUM transfer → SYNC of the next frame in the following cycle, `overrun`=0.
- **Sequence wrap:** 257 spaced edges → SEQ runs …FE,FF,00. `drop_count` is checked for saturation with 300 forced overruns (value 255).
- **Reset mid-frame:** `rst_n` low during DATA → `tx_valid`, `busy` and `drop_count` are 0 at once. After release, the first frame has SEQ=00.
